// File: rtl/ps2_key_decoder_if.sv
// Key-event stream between the scan-code decoder and its consumer.
//   ev_valid  head event available (decoder -> consumer)
//   ev_ready  consumer accepts head this cycle (consumer -> decoder)
//   ev_code   head base scan code, prefixes stripped
//   ev_ext    head was E0-prefixed
//   ev_break  head is a key release (1) or press (0)
//   ev_ascii  head ASCII translation, 8'h00 when unmapped or extended
interface ps2_key_decoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] ev_ascii;

  modport master (
    output ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
    output ev_ready
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder. Folds E0/F0 prefixes into single key events,
// suppresses typematic repeats, translates to ASCII and queues events in a
// show-ahead FIFO.
//   clk, reset        single clock, synchronous active-high reset
//   code_valid, code  one-cycle strobe with a received scan-code byte
//   ev                event stream (master side), valid/ready handshake
//   key_count         accepted press events, wraps at 255
//   overflow          sticky: an event was dropped on a full FIFO
module ps2_key_decoder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [7:0]        code,
  ps2_key_decoder_if.master ev,
  output logic [7:0]        key_count,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } event_t;

  state_t        state;
  logic [7:0]    held_code;
  logic          held_ext;
  logic          held_vld;
  event_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  function automatic logic [7:0] to_ascii(input logic [7:0] c);
    case (c)
      8'h1C: to_ascii = 8'h61; 8'h32: to_ascii = 8'h62; 8'h21: to_ascii = 8'h63;
      8'h23: to_ascii = 8'h64; 8'h24: to_ascii = 8'h65; 8'h2B: to_ascii = 8'h66;
      8'h34: to_ascii = 8'h67; 8'h33: to_ascii = 8'h68; 8'h43: to_ascii = 8'h69;
      8'h3B: to_ascii = 8'h6A; 8'h42: to_ascii = 8'h6B; 8'h4B: to_ascii = 8'h6C;
      8'h3A: to_ascii = 8'h6D; 8'h31: to_ascii = 8'h6E; 8'h44: to_ascii = 8'h6F;
      8'h4D: to_ascii = 8'h70; 8'h15: to_ascii = 8'h71; 8'h2D: to_ascii = 8'h72;
      8'h1B: to_ascii = 8'h73; 8'h2C: to_ascii = 8'h74; 8'h3C: to_ascii = 8'h75;
      8'h2A: to_ascii = 8'h76; 8'h1D: to_ascii = 8'h77; 8'h22: to_ascii = 8'h78;
      8'h35: to_ascii = 8'h79; 8'h1A: to_ascii = 8'h7A;
      8'h45: to_ascii = 8'h30; 8'h16: to_ascii = 8'h31; 8'h1E: to_ascii = 8'h32;
      8'h26: to_ascii = 8'h33; 8'h25: to_ascii = 8'h34; 8'h2E: to_ascii = 8'h35;
      8'h36: to_ascii = 8'h36; 8'h3D: to_ascii = 8'h37; 8'h3E: to_ascii = 8'h38;
      8'h46: to_ascii = 8'h39;
      8'h29: to_ascii = 8'h20; 8'h5A: to_ascii = 8'h0D; 8'h66: to_ascii = 8'h08;
      default: to_ascii = 8'h00;
    endcase
  endfunction

  logic is_prefix;
  logic is_sys;
  logic emit;
  logic emit_ext;
  logic emit_brk;
  logic held_match;
  logic accept;
  logic full;
  logic pop;
  logic push;

  assign is_prefix = (code == 8'hE0) || (code == 8'hF0);
  assign is_sys    = (code == 8'hAA) || (code == 8'hFA) ||
                     (code == 8'hFE) || (code == 8'hEE);

  // Event decode for the byte presented this cycle, from the prefix state.
  always_comb begin
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (code_valid && !reset && !is_prefix) begin
      unique case (state)
        IDLE:    emit = !is_sys;
        EXT:     begin emit = 1'b1; emit_ext = 1'b1; end
        BRK:     begin emit = 1'b1; emit_brk = 1'b1; end
        EXTBRK:  begin emit = 1'b1; emit_ext = 1'b1; emit_brk = 1'b1; end
        default: emit = 1'b0;
      endcase
    end
  end

  assign held_match = held_vld && ({held_ext, held_code} == {emit_ext, code});
  // Releases always pass; presses matching the held key are typematic repeats.
  assign accept = emit && (emit_brk || !held_match);
  assign full   = (count == (AW + 1)'(DEPTH));
  assign pop    = (count != '0) && ev.ev_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push   = accept && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      held_code <= '0;
      held_ext  <= 1'b0;
      held_vld  <= 1'b0;
      key_count <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (code_valid) begin
        unique case (state)
          IDLE: begin
            if (code == 8'hE0)      state <= EXT;
            else if (code == 8'hF0) state <= BRK;
          end
          EXT: begin
            if (code == 8'hF0)      state <= EXTBRK;
            else if (code != 8'hE0) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      if (accept) begin
        if (!emit_brk) begin
          held_code <= code;
          held_ext  <= emit_ext;
          held_vld  <= 1'b1;
          key_count <= key_count + 8'd1;
        end else if (held_match) begin
          held_vld <= 1'b0;
        end
        if (full && !pop) overflow <= 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{code:  code,
                       ext:   emit_ext,
                       brk:   emit_brk,
                       ascii: emit_ext ? 8'h00 : to_ascii(code)};
    end
  end

  event_t head;
  assign head        = (count != '0) ? mem[rd_ptr] : '0;
  assign ev.ev_valid = (count != '0);
  assign ev.ev_code  = head.code;
  assign ev.ev_ext   = head.ext;
  assign ev.ev_break = head.brk;
  assign ev.ev_ascii = head.ascii;

endmodule
